// File: rtl/grant_decoder_arbiter_if.sv
// Request/grant bundle between the eight requesters and the arbiter that
// owns the shared 3-to-8 select decoder.
interface grant_decoder_arbiter_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  // Requester side: raises requests and releases, observes the grant
  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  preempt
  );

  // Arbiter side: samples requests, drives the registered grant
  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output preempt
  );
endinterface

// File: rtl/grant_decoder_arbiter.sv
// Round-robin arbiter for eight requesters sharing one 3-to-8 select decoder.
// One owner at a time; the grant ends on done, on the owner dropping its
// request, or when the programmable hold limit runs out (flagged by preempt).
module grant_decoder_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  grant_decoder_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Hold limit is active only for a non-zero MAX_HOLD; the counter is cleared
  // on the first grant cycle, so MAX_HOLD-1 marks the last allowed cycle.
  localparam logic       HOLD_EN   = (MAX_HOLD != 32'd0);
  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 32'd0) ? 8'd0 : 8'(MAX_HOLD - 32'd1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_last;
  logic [2:0] r_idx;
  logic [7:0] r_cnt;
  logic [7:0] r_gnt;
  logic       r_valid;
  logic       r_preempt;

  logic [2:0] w_idx_nxt;
  logic [2:0] w_last_nxt;
  logic [7:0] w_cnt_nxt;
  logic [7:0] w_gnt_nxt;
  logic       w_valid_nxt;
  logic       w_preempt_nxt;

  logic       w_any_req;
  logic [2:0] w_winner;
  logic       w_rel_done;
  logic       w_rel_drop;
  logic       w_rel_tmo;
  logic       w_release;

  // First set request bit searching from last+1 upward with 3-bit wrap;
  // offset 8 wraps back onto last itself so a lone previous owner still wins.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] last);
    logic [2:0] idx;
    logic [2:0] pick;
    logic       found;
    pick  = 3'd0;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = last + k[2:0];
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  assign w_any_req  = |bus.req;
  assign w_winner   = rr_pick(bus.req, r_last);
  assign w_rel_done = bus.done;
  assign w_rel_drop = ~bus.req[r_idx];
  assign w_rel_tmo  = HOLD_EN && (r_cnt == HOLD_LAST);
  assign w_release  = w_rel_done | w_rel_drop | w_rel_tmo;

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= 3'd0;
      r_last    <= 3'd7;
      r_cnt     <= 8'd0;
      r_gnt     <= 8'd0;
      r_valid   <= 1'b0;
      r_preempt <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_last    <= w_last_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gnt     <= w_gnt_nxt;
      r_valid   <= w_valid_nxt;
      r_preempt <= w_preempt_nxt;
    end
  end

  // Next state: arbitrate from IDLE, leave GRANT on any release condition
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ST_GRANT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_GRANT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, pointer and hold counter
  always_comb begin
    w_idx_nxt     = r_idx;
    w_last_nxt    = r_last;
    w_cnt_nxt     = r_cnt;
    w_valid_nxt   = 1'b0;
    w_preempt_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_idx_nxt   = w_winner;
          w_last_nxt  = w_winner;
          w_cnt_nxt   = 8'd0;
          w_valid_nxt = 1'b1;
        end else begin
          w_valid_nxt = 1'b0;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_valid_nxt   = 1'b0;
          // A coinciding done or request drop makes the release voluntary
          w_preempt_nxt = w_rel_tmo & ~w_rel_done & ~w_rel_drop;
        end else begin
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = (r_cnt == 8'hFF) ? r_cnt : (r_cnt + 8'd1);
        end
      end
      default: begin
        w_valid_nxt   = 1'b0;
        w_preempt_nxt = 1'b0;
      end
    endcase
    w_gnt_nxt = w_valid_nxt ? (8'd1 << w_idx_nxt) : 8'd0;
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_idx   = r_idx;
  assign bus.gnt_valid = r_valid;
  assign bus.preempt   = r_preempt;

endmodule

// File: tb/tb_grant_decoder_arbiter.sv
// Bench for grant_decoder_arbiter: two instances (hold limit 4 and no limit)
// share one stimulus stream; a behavioural model of each is compared on every
// cycle, alongside hand-computed directed expectations.
module tb_grant_decoder_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic       chk_en;
  int         n_checks;
  int         n_fail;

  grant_decoder_arbiter_if bus4 ();
  grant_decoder_arbiter_if bus0 ();

  assign bus4.req  = req;
  assign bus4.done = done;
  assign bus0.req  = req;
  assign bus0.done = done;

  grant_decoder_arbiter #(.MAX_HOLD(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  grant_decoder_arbiter #(.MAX_HOLD(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: who owns the resource, for how many cycles, and the pointer
  typedef struct packed {
    logic       busy;
    logic [2:0] owner;
    logic [2:0] last;
    int         held;
    logic       pre;
  } mstate_t;

  mstate_t m [2];
  int      mh [2];
  initial begin
    mh[0] = 4;
    mh[1] = 0;
  end

  function automatic mstate_t model_step(mstate_t s, logic [7:0] r, logic d, int lim, logic rn);
    mstate_t n;
    int      c;
    logic    found;
    n     = s;
    n.pre = 1'b0;
    found = 1'b0;
    if (!rn) begin
      n.busy = 1'b0; n.owner = 3'd0; n.last = 3'd7; n.held = 0;
    end else if (s.busy) begin
      if (d || !r[s.owner] || (lim != 0 && s.held == lim)) begin
        n.busy = 1'b0;
        n.pre  = !d && r[s.owner];
      end else begin
        n.held = s.held + 1;
      end
    end else if (r != 8'd0) begin
      for (int i = 1; i <= 8; i++) begin
        c = (int'(s.last) + i) % 8;
        if (!found && r[c]) begin
          n.owner = 3'(c);
          found   = 1'b1;
        end
      end
      n.busy = 1'b1;
      n.last = n.owner;
      n.held = 1;
    end
    return n;
  endfunction

  function automatic logic [12:0] model_out(mstate_t s);
    logic [7:0] g;
    g = s.busy ? (8'd1 << s.owner) : 8'd0;
    return {g, s.owner, s.busy, s.pre};
  endfunction

  // Advance both models on every rising edge
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      m[k] <= model_step(m[k], req, done, mh[k], rst_n);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [12:0] act_vec [2];
  assign act_vec[0] = {bus4.gnt, bus4.gnt_idx, bus4.gnt_valid, bus4.preempt};
  assign act_vec[1] = {bus0.gnt, bus0.gnt_idx, bus0.gnt_valid, bus0.preempt};

  // Every-cycle comparison of both DUTs against their models
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk((k == 0) ? "model_mh4" : "model_mh0", 32'(act_vec[k]), 32'(model_out(m[k])));
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    chk_en   = 1'b0;
    rst_n    = 1'b0;
    req      = 8'hFF;
    done     = 1'b0;

    // Reset held for two edges with all requesting
    tick(1);
    chk_en = 1'b1;
    tick(1);
    chk("rst_gnt",     32'(bus4.gnt),       32'h00);
    chk("rst_idx",     32'(bus4.gnt_idx),   32'd0);
    chk("rst_valid",   32'(bus4.gnt_valid), 32'd0);
    chk("rst_preempt", 32'(bus4.preempt),   32'd0);
    rst_n = 1'b1;
    tick(1);
    chk("first_gnt", 32'(bus4.gnt), 32'h01);
    req = 8'h00;
    tick(2);

    // Single requester, then drop
    req = 8'h20;
    tick(1);
    chk("single_gnt", 32'(bus4.gnt),     32'h20);
    chk("single_idx", 32'(bus4.gnt_idx), 32'd5);
    req = 8'h00;
    tick(1);
    chk("drop_gnt",     32'(bus4.gnt),     32'h00);
    chk("drop_preempt", 32'(bus4.preempt), 32'd0);

    // Rotation from a fresh pointer, done held high (ignored in IDLE)
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    req   = 8'hFF;
    done  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      chk("rot_gnt", 32'(bus4.gnt), (i % 2 == 0) ? (32'd1 << (i / 2)) : 32'd0);
    end
    req = 8'h81;
    tick(1);
    chk("wrap_gnt0", 32'(bus4.gnt), 32'h01);
    tick(2);
    chk("wrap_gnt7", 32'(bus4.gnt), 32'h80);
    tick(1);
    req  = 8'h00;
    done = 1'b0;
    tick(2);

    // Timeout: limit 4 preempts owner 0 and hands over to 3; no limit holds
    req = 8'h09;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("hold_gnt", 32'(bus4.gnt), 32'h01);
    end
    tick(1);
    chk("tmo_gnt",     32'(bus4.gnt),     32'h00);
    chk("tmo_preempt", 32'(bus4.preempt), 32'd1);
    chk("nolim_gnt",   32'(bus0.gnt),     32'h01);
    tick(1);
    chk("next_gnt",    32'(bus4.gnt),     32'h08);
    chk("next_idx",    32'(bus4.gnt_idx), 32'd3);
    tick(20);
    chk("nolim_long_gnt",     32'(bus0.gnt),     32'h01);
    chk("nolim_long_preempt", 32'(bus0.preempt), 32'd0);
    req = 8'h00;
    tick(2);

    // done coinciding with the last hold cycle is a voluntary release
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    req   = 8'h01;
    tick(4);
    chk("sim_held", 32'(bus4.gnt), 32'h01);
    done = 1'b1;
    tick(1);
    chk("sim_gnt",     32'(bus4.gnt),     32'h00);
    chk("sim_preempt", 32'(bus4.preempt), 32'd0);
    done = 1'b0;
    req  = 8'h00;
    tick(2);

    // Reset in the middle of a grant
    req = 8'h10;
    tick(2);
    chk("mid_gnt", 32'(bus4.gnt), 32'h10);
    rst_n = 1'b0;
    tick(1);
    chk("midrst_gnt",     32'(bus4.gnt),       32'h00);
    chk("midrst_idx",     32'(bus4.gnt_idx),   32'd0);
    chk("midrst_valid",   32'(bus4.gnt_valid), 32'd0);
    chk("midrst_preempt", 32'(bus4.preempt),   32'd0);
    rst_n = 1'b1;
    tick(1);
    chk("regrant_gnt", 32'(bus4.gnt),     32'h10);
    chk("regrant_idx", 32'(bus4.gnt_idx), 32'd4);
    req = 8'h00;
    tick(2);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
